issue_scoreboard: RTL and testbench
===================================

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 Parameter LOAD_LAT, default 2, meaning cycles from load issue until its data is forwardable on the memory-result path (range 1..7).
REQ-002 Parameter DIV_LAT, default 32, meaning cycles the multi-cycle divider occupies before its result is forwardable (range 2..63).
REQ-003 Ports, in order:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- issue_valid  in  1  master instruction attempts issue.
- master_rs, master_rt  in  5  master source registers.
- master_wen  in  1  master writes a GPR.
- master_waddr  in  5  master destination register.
- master_is_load  in  1  master is a load.
- master_is_div  in  1  master starts the divider.
- slave_valid  in  1  slave instruction attempts issue.
- slave_rs, slave_rt  in  5  slave source registers.
- flush  in  1  pipeline flush.
- master_stall  out  1  master (and slave) must not issue.
- slave_block  out  1  slave must not issue this cycle.
- div_busy  out  1  divider state is BUSY.
- ld_full  out  1  both load entries are occupied.

Function
REQ-004 The block SHALL hold two load entries {valid, waddr[4:0], cnt[2:0]}; an entry is pending while valid and cnt != 0.
REQ-005 Hazard match SHALL mean: source register == entry/div destination, with register 0 never matching.
REQ-006 master_stall SHALL be combinational: issue_valid AND (master_rs/rt match a pending load entry, OR master_is_load with ld_full, OR div_busy with master_is_div, OR div_busy with master_rs/rt matching the div destination).
REQ-007 slave_block SHALL be 1 when master_stall, or slave_valid AND (slave_rs/rt match a pending load or busy div destination, OR master_wen with master_waddr matching slave_rs/rt, OR master_is_load, OR master_is_div).
REQ-008 On an accepted load (issue_valid, !master_stall, master_is_load, master_waddr != 0), the lowest free entry SHALL load {1, master_waddr, LOAD_LAT} at the next edge.
REQ-009 Every valid entry with cnt != 0 SHALL decrement once per cycle; at cnt == 0 it SHALL clear valid at the following edge.
REQ-010 A free entry SHALL be one with valid == 0 or cnt == 0; allocation into an entry reaching 0 in the same cycle SHALL be legal.
REQ-011 The divider FSM SHALL have states IDLE, BUSY, DONE: IDLE->BUSY on an accepted master_is_div (latching master_waddr, counter = DIV_LAT-1); BUSY decrements, BUSY->DONE at counter 0; DONE->IDLE unconditionally after one cycle.
REQ-012 div_busy SHALL be 1 only in BUSY; in DONE the result is forwardable and no stall is raised.
REQ-013 flush SHALL, at the next edge, clear all load entries and force the FSM to IDLE; flush wins over a simultaneous allocation or div start.
REQ-014 ld_full SHALL be 1 when both entries are pending.

Reset
REQ-015 While rst is 1, all entries SHALL be invalid with cnt 0, the FSM SHALL be IDLE with counter 0, and all outputs SHALL read 0 (slave_block reads 1 if SLAVE_ISSUE_EN is absent).
REQ-016 Assertion of rst mid-load or mid-divide SHALL abandon the operation with no stall after release.

Configuration
REQ-017 With macro ISSUE_SCOREBOARD_SLAVE_ISSUE_EN defined, slave_block SHALL follow REQ-007; without it, slave_block SHALL be constant 1 (single-issue), and the slave-side compare logic SHALL be absent.

Verification
REQ-018 Load to r5 issued at cycle 0, master_rs=5 at cycles 1-2 -> master_stall=1 at cycles 1 and 2, 0 at cycle 3 (LOAD_LAT=2).
REQ-019 Two back-to-back loads to r3, r4, third load at cycle 2 -> ld_full=1 and master_stall=1 at cycle 2; the load is accepted at cycle 3.
REQ-020 Div to r8 at cycle 0, master_rt=8 -> div_busy=1 and master_stall=1 for cycles 1..32, state DONE at cycle 33, no stall at cycle 33.
REQ-021 Master add writes r7, slave reads r7 -> slave_block=1, master_stall=0; with the macro undefined -> slave_block=1 always.
REQ-022 flush at cycle 5 of a divide, with a load to r2 pending -> at cycle 6, div_busy=0, master_rs=2 gives no stall.
REQ-023 Load to r0 -> no entry allocated; master_rs=0 on the next cycle gives master_stall=0.

Source files
------------

// File: rtl/issue_scoreboard.sv
// Issue hazard scoreboard: two load-latency entries plus a multi-cycle divider tracker.
// Define ISSUE_SCOREBOARD_SLAVE_ISSUE_EN for dual issue; without it the slave never issues.
module issue_scoreboard #(
    parameter int LOAD_LAT = 2,
    parameter int DIV_LAT  = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [4:0] master_rs,
    input  logic [4:0] master_rt,
    input  logic       master_wen,
    input  logic [4:0] master_waddr,
    input  logic       master_is_load,
    input  logic       master_is_div,
    input  logic       slave_valid,
    input  logic [4:0] slave_rs,
    input  logic [4:0] slave_rt,
    input  logic       flush,
    output logic       master_stall,
    output logic       slave_block,
    output logic       div_busy,
    output logic       ld_full
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    localparam logic [2:0] LOAD_INIT = 3'(LOAD_LAT);
    localparam logic [5:0] DIV_INIT  = 6'(DIV_LAT - 1);

    logic       ld_valid [2];
    logic [4:0] ld_waddr [2];
    logic [2:0] ld_cnt   [2];
    logic [1:0] ld_pending;
    logic [1:0] ld_alloc;

    div_state_t div_state, div_state_next;
    logic [5:0] div_cnt, div_cnt_next;
    logic [4:0] div_waddr, div_waddr_next;

    logic load_hit, div_hit, stall, load_accept, div_start;

    // Register 0 is hardwired, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

    always_comb begin
        ld_pending = '0;
        load_hit   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ld_pending[i] = ld_valid[i] && (ld_cnt[i] != 3'd0);
            if (ld_pending[i] &&
                (reg_match(master_rs, ld_waddr[i]) || reg_match(master_rt, ld_waddr[i])))
                load_hit = 1'b1;
        end
    end

    assign ld_full      = &ld_pending;
    assign div_busy     = (div_state == BUSY);
    assign div_hit      = div_busy &&
                          (reg_match(master_rs, div_waddr) || reg_match(master_rt, div_waddr));
    assign stall        = issue_valid && (load_hit || (master_is_load && ld_full) ||
                                          (div_busy && master_is_div) || div_hit);
    assign master_stall = stall;
    assign load_accept  = issue_valid && !stall && master_is_load && (master_waddr != 5'd0);
    assign div_start    = issue_valid && !stall && master_is_div && (div_state == IDLE);

    // An entry whose count has run out is free even before its valid bit drops.
    always_comb begin
        ld_alloc    = '0;
        ld_alloc[0] = load_accept && !ld_pending[0];
        ld_alloc[1] = load_accept && ld_pending[0] && !ld_pending[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                ld_valid[i] <= 1'b0;
                ld_waddr[i] <= '0;
                ld_cnt[i]   <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < 2; i++) begin
                ld_valid[i] <= 1'b0;
                ld_waddr[i] <= '0;
                ld_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ld_alloc[i]) begin
                    ld_valid[i] <= 1'b1;
                    ld_waddr[i] <= master_waddr;
                    ld_cnt[i]   <= LOAD_INIT;
                end else if (ld_valid[i]) begin
                    if (ld_cnt[i] != 3'd0)
                        ld_cnt[i] <= ld_cnt[i] - 3'd1;
                    else
                        ld_valid[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_state <= IDLE;
            div_cnt   <= '0;
            div_waddr <= '0;
        end else begin
            div_state <= div_state_next;
            div_cnt   <= div_cnt_next;
            div_waddr <= div_waddr_next;
        end
    end

    // DONE lasts one cycle: the result forwards there, so nothing stalls on it.
    always_comb begin
        div_state_next = div_state;
        div_cnt_next   = div_cnt;
        div_waddr_next = div_waddr;
        if (flush) begin
            div_state_next = IDLE;
            div_cnt_next   = '0;
        end else begin
            case (div_state)
                IDLE: if (div_start) begin
                    div_state_next = BUSY;
                    div_cnt_next   = DIV_INIT;
                    div_waddr_next = master_waddr;
                end
                BUSY: begin
                    if (div_cnt == 6'd0)
                        div_state_next = DONE;
                    else
                        div_cnt_next = div_cnt - 6'd1;
                end
                DONE:    div_state_next = IDLE;
                default: div_state_next = IDLE;
            endcase
        end
    end

`ifdef ISSUE_SCOREBOARD_SLAVE_ISSUE_EN
    logic slave_hit;

    always_comb begin
        slave_hit = 1'b0;
        for (int i = 0; i < 2; i++)
            if (ld_pending[i] &&
                (reg_match(slave_rs, ld_waddr[i]) || reg_match(slave_rt, ld_waddr[i])))
                slave_hit = 1'b1;
        if (div_busy && (reg_match(slave_rs, div_waddr) || reg_match(slave_rt, div_waddr)))
            slave_hit = 1'b1;
        if (master_wen &&
            (reg_match(slave_rs, master_waddr) || reg_match(slave_rt, master_waddr)))
            slave_hit = 1'b1;
        if (master_is_load || master_is_div)
            slave_hit = 1'b1;
    end

    assign slave_block = !rst && (stall || (slave_valid && slave_hit));
`else
    logic unused_slave;
    assign unused_slave = ^{slave_valid, slave_rs, slave_rt, master_wen};
    assign slave_block  = 1'b1;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Randomized bench for issue_scoreboard against a timestamp-based reference model,
// preceded by short directed scenarios for the latency and flush/reset corner cases.
module tb_issue_scoreboard;

    localparam int LOAD_LAT = 2;
    localparam int DIV_LAT  = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       issue_valid = 1'b0;
    logic [4:0] master_rs = '0, master_rt = '0, master_waddr = '0;
    logic       master_wen = 1'b0, master_is_load = 1'b0, master_is_div = 1'b0;
    logic       slave_valid = 1'b0;
    logic [4:0] slave_rs = '0, slave_rt = '0;
    logic       flush = 1'b0;
    logic       master_stall, slave_block, div_busy, ld_full;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    int s_iv, s_rs, s_rt, s_wen, s_waddr, s_ld, s_dv, s_sv, s_srs, s_srt, s_fl;

    // Reference state: each in-flight load is a destination plus the first cycle it is no longer pending.
    int ld_dst_q[$];
    int ld_ready_q[$];
    int div_start_cyc = -1000;
    int div_dst = 0;
    bit last_stall;

    issue_scoreboard #(.LOAD_LAT(LOAD_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid),
        .master_rs(master_rs), .master_rt(master_rt), .master_wen(master_wen),
        .master_waddr(master_waddr), .master_is_load(master_is_load),
        .master_is_div(master_is_div), .slave_valid(slave_valid),
        .slave_rs(slave_rs), .slave_rt(slave_rt), .flush(flush),
        .master_stall(master_stall), .slave_block(slave_block),
        .div_busy(div_busy), .ld_full(ld_full)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %b expected %b (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit hit_reg(input int src, input int dst);
        return (src != 0) && (src == dst);
    endfunction

    function automatic bit ld_hit(input int r);
        foreach (ld_dst_q[i])
            if (ld_ready_q[i] > cyc && hit_reg(r, ld_dst_q[i])) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int ld_count();
        int n = 0;
        foreach (ld_ready_q[i]) if (ld_ready_q[i] > cyc) n++;
        return n;
    endfunction

    function automatic bit m_busy();
        return (cyc > div_start_cyc) && (cyc <= div_start_cyc + DIV_LAT);
    endfunction

    function automatic bit m_idle();
        return cyc > div_start_cyc + DIV_LAT + 1;
    endfunction

    function automatic bit exp_stall();
        return (s_iv != 0) && (ld_hit(s_rs) || ld_hit(s_rt) ||
               (s_ld != 0 && ld_count() == 2) || (m_busy() && s_dv != 0) ||
               (m_busy() && (hit_reg(s_rs, div_dst) || hit_reg(s_rt, div_dst))));
    endfunction

    task automatic applyStimulus(input int iv, rs, rt, wen, waddr, ld, dv, sv, srs, srt, fl);
        s_iv = iv; s_rs = rs; s_rt = rt; s_wen = wen; s_waddr = waddr;
        s_ld = ld; s_dv = dv; s_sv = sv; s_srs = srs; s_srt = srt; s_fl = fl;
        issue_valid    = (iv != 0);
        master_rs      = 5'(rs);
        master_rt      = 5'(rt);
        master_wen     = (wen != 0);
        master_waddr   = 5'(waddr);
        master_is_load = (ld != 0);
        master_is_div  = (dv != 0);
        slave_valid    = (sv != 0);
        slave_rs       = 5'(srs);
        slave_rt       = 5'(srt);
        flush          = (fl != 0);
    endtask

    task automatic check_cycle();
        bit e_slave;
        @(negedge clk);
        last_stall = exp_stall();
        checkOutput("master_stall", master_stall, last_stall);
        checkOutput("div_busy", div_busy, m_busy());
        checkOutput("ld_full", ld_full, ld_count() == 2);
`ifdef ISSUE_SCOREBOARD_SLAVE_ISSUE_EN
        e_slave = last_stall || (s_sv != 0 && (ld_hit(s_srs) || ld_hit(s_srt) ||
                  (m_busy() && (hit_reg(s_srs, div_dst) || hit_reg(s_srt, div_dst))) ||
                  (s_wen != 0 && (hit_reg(s_srs, s_waddr) || hit_reg(s_srt, s_waddr))) ||
                  s_ld != 0 || s_dv != 0));
`else
        e_slave = 1'b1;
`endif
        checkOutput("slave_block", slave_block, e_slave);
    endtask

    task automatic clear_model();
        ld_dst_q.delete();
        ld_ready_q.delete();
        div_start_cyc = cyc - 1000;
    endtask

    task automatic finish_cycle();
        for (int i = ld_ready_q.size() - 1; i >= 0; i--)
            if (ld_ready_q[i] <= cyc) begin
                ld_ready_q.delete(i);
                ld_dst_q.delete(i);
            end
        if (s_fl != 0) begin
            clear_model();
        end else if (s_iv != 0 && !last_stall) begin
            if (s_ld != 0 && s_waddr != 0) begin
                ld_dst_q.push_back(s_waddr);
                ld_ready_q.push_back(cyc + 1 + LOAD_LAT);
            end
            if (s_dv != 0 && m_idle()) begin
                div_start_cyc = cyc;
                div_dst       = s_waddr;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_cycle();
        check_cycle();
        finish_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            run_cycle();
        end
    endtask

    // Inputs are deliberately busy during reset so the forced-quiet outputs mean something.
    task automatic do_reset();
        rst = 1'b1;
        applyStimulus(1, 3, 4, 1, 3, 1, 1, 1, 3, 4, 0);
        @(negedge clk);
        checkOutput("rst_master_stall", master_stall, 1'b0);
        checkOutput("rst_div_busy", div_busy, 1'b0);
        checkOutput("rst_ld_full", ld_full, 1'b0);
`ifdef ISSUE_SCOREBOARD_SLAVE_ISSUE_EN
        checkOutput("rst_slave_block", slave_block, 1'b0);
`else
        checkOutput("rst_slave_block", slave_block, 1'b1);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc++;
        clear_model();
    endtask

    initial begin
        do_reset();

        // Load-use latency on r5.
        applyStimulus(1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0); run_cycle();
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            check_cycle();
            checkOutput($sformatf("load_use_c%0d", c), master_stall, c <= 2);
            finish_cycle();
        end
        idle(3);

        // Both load entries occupied, third load waits one cycle.
        applyStimulus(1, 0, 0, 1, 3, 1, 0, 0, 0, 0, 0); run_cycle();
        applyStimulus(1, 0, 0, 1, 4, 1, 0, 0, 0, 0, 0); run_cycle();
        applyStimulus(1, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0);
        check_cycle();
        checkOutput("full_ld_full", ld_full, 1'b1);
        checkOutput("full_stall", master_stall, 1'b1);
        finish_cycle();
        applyStimulus(1, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0);
        check_cycle();
        checkOutput("full_accept", master_stall, 1'b0);
        finish_cycle();
        idle(4);

        // Divide to r8 with a dependent reader.
        applyStimulus(1, 0, 0, 1, 8, 0, 1, 0, 0, 0, 0); run_cycle();
        for (int c = 1; c <= DIV_LAT + 1; c++) begin
            applyStimulus(1, 0, 8, 0, 0, 0, 0, 0, 0, 0, 0);
            check_cycle();
            checkOutput($sformatf("div_busy_c%0d", c), div_busy, c <= DIV_LAT);
            checkOutput($sformatf("div_stall_c%0d", c), master_stall, c <= DIV_LAT);
            finish_cycle();
        end
        idle(2);

        // Master writes r7 while slave reads r7.
        applyStimulus(1, 0, 0, 1, 7, 0, 0, 1, 7, 0, 0);
        check_cycle();
        checkOutput("raw_master_stall", master_stall, 1'b0);
        checkOutput("raw_slave_block", slave_block, 1'b1);
        finish_cycle();

        // Flush during a divide with a load to r2 pending.
        applyStimulus(1, 0, 0, 1, 9, 0, 1, 0, 0, 0, 0); run_cycle();
        idle(3);
        applyStimulus(1, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0); run_cycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); run_cycle();
        applyStimulus(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle();
        checkOutput("flush_div_busy", div_busy, 1'b0);
        checkOutput("flush_load_stall", master_stall, 1'b0);
        finish_cycle();

        // Flush beats an allocation in the same cycle.
        applyStimulus(1, 0, 0, 1, 5, 1, 0, 0, 0, 0, 1); run_cycle();
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle();
        checkOutput("flush_alloc_stall", master_stall, 1'b0);
        finish_cycle();

        // Load to r0 allocates nothing.
        applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0); run_cycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle();
        checkOutput("r0_stall", master_stall, 1'b0);
        finish_cycle();

        // Reset mid-divide and mid-load leaves no residual stall.
        applyStimulus(1, 0, 0, 1, 8, 0, 1, 0, 0, 0, 0); run_cycle();
        applyStimulus(1, 0, 0, 1, 6, 1, 0, 0, 0, 0, 0); run_cycle();
        do_reset();
        applyStimulus(1, 6, 8, 0, 0, 0, 0, 0, 0, 0, 0);
        check_cycle();
        checkOutput("rst_abandon_stall", master_stall, 1'b0);
        checkOutput("rst_abandon_busy", div_busy, 1'b0);
        finish_cycle();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                applyStimulus(int'($urandom_range(0, 9) < 8), $urandom_range(0, 7),
                              $urandom_range(0, 7), $urandom_range(0, 1),
                              $urandom_range(0, 7), int'($urandom_range(0, 9) < 3),
                              int'($urandom_range(0, 39) == 0), $urandom_range(0, 1),
                              $urandom_range(0, 7), $urandom_range(0, 7),
                              int'($urandom_range(0, 59) == 0));
                run_cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
